// File: rtl/rca_ft_pkg.sv
// ---------------------------------------------------------------------------
// rca_ft_pkg
// Shared constants and helpers for the fault-tolerant ripple-carry adder.
//   N_BITS     logical adder width
//   N_CELLS    physical full-adder cells (N_BITS active plus one spare)
//   SPARE_IDX  physical index of the spare cell, also "nothing bypassed"
//   decode_bypass()  maps the 3-bit bypass code to the bypassed cell index
//   steer_bit()      picks the operand bit a physical cell sees in normal mode
// ---------------------------------------------------------------------------
package rca_ft_pkg;

  localparam int N_BITS = 4;
  localparam int N_CELLS = 5;
  localparam logic [2:0] SPARE_IDX = 3'd4;

  // Codes 1..5 bypass physical cell code-1. Every other code leaves the
  // spare (cell 4) idle, so the four low cells form a plain adder.
  function automatic logic [2:0] decode_bypass(input logic [2:0] is_code);
    logic [2:0] k;
    k = SPARE_IDX;
    if ((is_code >= 3'd1) && (is_code <= 3'd5)) begin
      k = is_code - 3'd1;
    end
    return k;
  endfunction

  // Physical cell 'idx' in normal mode: below the bypassed cell it carries
  // logical bit idx (hi_bit), the bypassed cell is fed 0, and above it the
  // cell carries logical bit idx-1 (lo_bit).
  function automatic logic steer_bit(input logic hi_bit,
                                     input logic lo_bit,
                                     input logic [2:0] idx,
                                     input logic [2:0] k);
    logic b;
    if (k > idx) begin
      b = hi_bit;
    end else if (k == idx) begin
      b = 1'b0;
    end else begin
      b = lo_bit;
    end
    return b;
  endfunction

endpackage

// File: rtl/rca_ft_cell.sv
// ---------------------------------------------------------------------------
// rca_ft_cell
// One full-adder cell with fault-inject XORs on its outputs.
//   i_x, i_y, i_ci  adder inputs
//   i_cs            1 inverts the carry-out
//   i_ss            1 inverts the sum
//   o_sum, o_co     post-inject sum and carry-out
// ---------------------------------------------------------------------------
module rca_ft_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_ci,
  input  logic i_cs,
  input  logic i_ss,
  output logic o_sum,
  output logic o_co
);

  logic w_sum_raw;
  logic w_co_raw;

  assign w_sum_raw = i_x ^ i_y ^ i_ci;
  assign w_co_raw  = (i_x & i_y) | (i_x & i_ci) | (i_y & i_ci);

  assign o_sum = w_sum_raw ^ i_ss;
  assign o_co  = w_co_raw ^ i_cs;

endmodule

// File: rtl/rca_ft_adder.sv
// ---------------------------------------------------------------------------
// rca_ft_adder
// 4-bit ripple-carry adder built from five full-adder cells, one of which is
// a spare. A bypass code removes any one cell from the chain and remaps the
// logical bits around it. A self-test mode chains all five cells with 5-bit
// operands. All outputs are registered (1-cycle latency).
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_a, i_b, i_c1        normal-mode operands and carry-in
//   i_test                1 = self-test mode
//   i_is0..i_is2          bypass code {is2,is1,is0}
//   i_cs0..i_cs4          carry-fault inject per physical cell
//   i_ss0..i_ss3          sum-fault inject per physical cell (none on spare)
//   i_ta, i_tb            self-test operands
//   o_s                   {carry, sum[3:0]} (test mode: 5-bit sum)
//   o_st, o_ct            post-inject sum / carry of physical cells 0..3
// ---------------------------------------------------------------------------
module rca_ft_adder
  import rca_ft_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_BITS-1:0]   i_a,
  input  logic [N_BITS-1:0]   i_b,
  input  logic                i_c1,
  input  logic                i_test,
  input  logic                i_is0,
  input  logic                i_is1,
  input  logic                i_is2,
  input  logic                i_cs0,
  input  logic                i_cs1,
  input  logic                i_cs2,
  input  logic                i_cs3,
  input  logic                i_cs4,
  input  logic                i_ss0,
  input  logic                i_ss1,
  input  logic                i_ss2,
  input  logic                i_ss3,
  input  logic [N_CELLS-1:0]  i_ta,
  input  logic [N_CELLS-1:0]  i_tb,
  output logic [N_CELLS-1:0]  o_s,
  output logic [N_BITS-1:0]   o_st,
  output logic [N_BITS-1:0]   o_ct
);

  logic [2:0]         w_k;
  logic [N_CELLS-1:0] w_x;
  logic [N_CELLS-1:0] w_y;
  logic [N_CELLS-1:0] w_sum;

  // Carries are kept as scalars so the ripple path is not seen as a
  // self-referencing vector; every cell only ever reads lower cells.
  logic w_ci0, w_ci1, w_ci2, w_ci3, w_ci4;
  logic w_co0, w_co1, w_co2, w_co3, w_co4;

  logic [N_CELLS-1:0] w_s_norm;
  logic [N_CELLS-1:0] w_s_next;
  logic [N_BITS-1:0]  w_ct_next;

  logic [N_CELLS-1:0] r_s;
  logic [N_BITS-1:0]  r_st;
  logic [N_BITS-1:0]  r_ct;

  assign w_k = decode_bypass({i_is2, i_is1, i_is0});

  // Operand steering. Cell 0 has no lower logical bit and cell 4 has no
  // higher one, hence the constant fill-ins.
  always_comb begin
    w_x = '0;
    w_y = '0;
    if (i_test) begin
      w_x = i_ta;
      w_y = i_tb;
    end else begin
      w_x[0] = steer_bit(i_a[0], 1'b0,   3'd0, w_k);
      w_x[1] = steer_bit(i_a[1], i_a[0], 3'd1, w_k);
      w_x[2] = steer_bit(i_a[2], i_a[1], 3'd2, w_k);
      w_x[3] = steer_bit(i_a[3], i_a[2], 3'd3, w_k);
      w_x[4] = steer_bit(1'b0,   i_a[3], 3'd4, w_k);
      w_y[0] = steer_bit(i_b[0], 1'b0,   3'd0, w_k);
      w_y[1] = steer_bit(i_b[1], i_b[0], 3'd1, w_k);
      w_y[2] = steer_bit(i_b[2], i_b[1], 3'd2, w_k);
      w_y[3] = steer_bit(i_b[3], i_b[2], 3'd3, w_k);
      w_y[4] = steer_bit(1'b0,   i_b[3], 3'd4, w_k);
    end
  end

  // Carry steering. The cell just above the bypassed one takes its carry
  // from the cell below the bypassed one (or c1 when cell 0 is bypassed).
  always_comb begin
    w_ci0 = 1'b0;
    w_ci1 = 1'b0;
    w_ci2 = 1'b0;
    w_ci3 = 1'b0;
    w_ci4 = 1'b0;
    if (i_test) begin
      w_ci1 = w_co0;
      w_ci2 = w_co1;
      w_ci3 = w_co2;
      w_ci4 = w_co3;
    end else begin
      if (w_k != 3'd0) w_ci0 = i_c1;

      if (w_k == 3'd0)      w_ci1 = i_c1;
      else if (w_k != 3'd1) w_ci1 = w_co0;

      if (w_k == 3'd1)      w_ci2 = w_co0;
      else if (w_k != 3'd2) w_ci2 = w_co1;

      if (w_k == 3'd2)      w_ci3 = w_co1;
      else if (w_k != 3'd3) w_ci3 = w_co2;

      if (w_k == 3'd3)      w_ci4 = w_co2;
      else if (w_k != 3'd4) w_ci4 = w_co3;
    end
  end

  rca_ft_cell u_cell0 (
    .i_x(w_x[0]), .i_y(w_y[0]), .i_ci(w_ci0), .i_cs(i_cs0), .i_ss(i_ss0),
    .o_sum(w_sum[0]), .o_co(w_co0)
  );
  rca_ft_cell u_cell1 (
    .i_x(w_x[1]), .i_y(w_y[1]), .i_ci(w_ci1), .i_cs(i_cs1), .i_ss(i_ss1),
    .o_sum(w_sum[1]), .o_co(w_co1)
  );
  rca_ft_cell u_cell2 (
    .i_x(w_x[2]), .i_y(w_y[2]), .i_ci(w_ci2), .i_cs(i_cs2), .i_ss(i_ss2),
    .o_sum(w_sum[2]), .o_co(w_co2)
  );
  rca_ft_cell u_cell3 (
    .i_x(w_x[3]), .i_y(w_y[3]), .i_ci(w_ci3), .i_cs(i_cs3), .i_ss(i_ss3),
    .o_sum(w_sum[3]), .o_co(w_co3)
  );
  rca_ft_cell u_cell4 (
    .i_x(w_x[4]), .i_y(w_y[4]), .i_ci(w_ci4), .i_cs(i_cs4), .i_ss(1'b0),
    .o_sum(w_sum[4]), .o_co(w_co4)
  );

  // Logical bit j lives in cell j below the bypassed cell, cell j+1 above.
  always_comb begin
    w_s_norm = '0;
    for (int j = 0; j < N_BITS; j++) begin
      if (int'(w_k) <= j) w_s_norm[j] = w_sum[j+1];
      else                w_s_norm[j] = w_sum[j];
    end
    w_s_norm[N_BITS] = (w_k == SPARE_IDX) ? w_co3 : w_co4;
  end

  // In test mode the top carry-out is dropped: s is the 5-bit sum.
  assign w_s_next  = i_test ? w_sum : w_s_norm;
  assign w_ct_next = {w_co3, w_co2, w_co1, w_co0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s  <= '0;
      r_st <= '0;
      r_ct <= '0;
    end else begin
      r_s  <= w_s_next;
      r_st <= w_sum[N_BITS-1:0];
      r_ct <= w_ct_next;
    end
  end

  assign o_s  = r_s;
  assign o_st = r_st;
  assign o_ct = r_ct;

endmodule

// File: tb/tb_rca_ft_adder.sv
module tb_rca_ft_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a, b;
  logic       c1, test;
  logic [2:0] is_code;
  logic [4:0] cs;
  logic [3:0] ss;
  logic [4:0] ta, tb;
  logic [4:0] s;
  logic [3:0] st, ct;

  int n_vec = 0;
  int n_err = 0;

  rca_ft_adder dut (
    .i_clk(clk), .i_rst(rst),
    .i_a(a), .i_b(b), .i_c1(c1), .i_test(test),
    .i_is0(is_code[0]), .i_is1(is_code[1]), .i_is2(is_code[2]),
    .i_cs0(cs[0]), .i_cs1(cs[1]), .i_cs2(cs[2]), .i_cs3(cs[3]), .i_cs4(cs[4]),
    .i_ss0(ss[0]), .i_ss1(ss[1]), .i_ss2(ss[2]), .i_ss3(ss[3]),
    .i_ta(ta), .i_tb(tb),
    .o_s(s), .o_st(st), .o_ct(ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic norm(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                      input logic [2:0] vis, input string tag, input logic [4:0] exp);
    a = va; b = vb; c1 = vc; is_code = vis; test = 1'b0;
    step();
    chk(tag, 8'(s), 8'(exp));
  endtask

  initial begin
    rst = 1'b1; a = 4'd15; b = 4'd15; c1 = 1'b0; test = 1'b0;
    is_code = 3'd0; cs = '0; ss = '0; ta = '0; tb = '0;

    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", 8'(s), 8'd0);
    chk("rst_st", 8'(st), 8'd0);
    chk("rst_ct", 8'(ct), 8'd0);
    rst = 1'b0;
    step();
    chk("first_after_rst", 8'(s), 8'd30);

    // Asynchronous reset mid-stream, checked between edges
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_s", 8'(s), 8'd0);
    chk("async_rst_ct", 8'(ct), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rerelease", 8'(s), 8'd30);

    // Normal mode, no faults
    norm(4'd1,  4'd2,  1'b0, 3'd0, "n_1_2",   5'd3);
    norm(4'd9,  4'd11, 1'b0, 3'd0, "n_9_11",  5'd20);
    norm(4'd12, 4'd11, 1'b0, 3'd0, "n_12_11", 5'd23);
    norm(4'd8,  4'd7,  1'b0, 3'd0, "n_8_7",   5'd15);
    norm(4'd1,  4'd14, 1'b0, 3'd0, "n_1_14",  5'd15);
    norm(4'd15, 4'd15, 1'b1, 3'd0, "n_15_15_c", 5'd31);
    norm(4'd6,  4'd5,  1'b1, 3'd7, "n_is7",   5'd12);
    norm(4'd6,  4'd5,  1'b0, 3'd6, "n_is6",   5'd11);

    // Carry fault on cell 0, then repair by bypassing it
    cs = 5'b00001;
    norm(4'd1, 4'd3, 1'b0, 3'd0, "fault_cs0", 5'd2);
    norm(4'd1, 4'd3, 1'b0, 3'd1, "repair_cs0", 5'd4);
    chk("repair_ct0", 8'(ct[0]), 8'd1);
    cs = '0;

    // Bypass sweep, with and without inject on the bypassed cell
    for (int k = 1; k <= 5; k++) begin
      norm(4'd9, 4'd3, 1'b0, 3'(k), $sformatf("byp_is%0d", k), 5'd12);
      cs = 5'd1 << (k - 1);
      if (k <= 4) ss = 4'd1 << (k - 1);
      norm(4'd9, 4'd3, 1'b0, 3'(k), $sformatf("byp_inj_is%0d", k), 5'd12);
      cs = '0; ss = '0;
    end
    // Carry-in routed around a bypassed cell 0 and cell 2
    norm(4'd15, 4'd0, 1'b1, 3'd1, "byp0_c1", 5'd16);
    norm(4'd7,  4'd1, 1'b1, 3'd3, "byp2_c1", 5'd9);
    // Faults on active cells still show with a bypass in place
    ss = 4'b1000;
    norm(4'd1, 4'd1, 1'b0, 3'd2, "byp1_ss3", 5'd6);
    ss = '0;

    // Self-test mode
    test = 1'b1; is_code = 3'd3; ta = 5'd9; tb = 5'd11;
    step();
    chk("t_s", 8'(s), 8'd20);
    chk("t_st", 8'(st), 8'b0100);
    chk("t_ct", 8'(ct), 8'b1011);
    ss = 4'b0100;
    step();
    chk("t_ss2", 8'(s), 8'd16);
    ss = '0;
    ta = 5'd31; tb = 5'd1;
    step();
    chk("t_wrap", 8'(s), 8'd0);
    cs = 5'b10000; ta = 5'd16; tb = 5'd16;
    step();
    chk("t_cs4_ignored", 8'(s), 8'd0);
    cs = 5'b00001; ta = 5'd0; tb = 5'd0;
    step();
    chk("t_cs0", 8'(s), 8'd2);
    chk("t_cs0_ct", 8'(ct), 8'b0001);
    cs = '0;

    // Mode consistency over random operands
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] ra, rb;
      logic [4:0] e;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      e = 5'(ra) + 5'(rb);
      a = ra; b = rb; c1 = 1'b0; is_code = 3'($urandom_range(0, 7));
      ta = {1'b0, ra}; tb = {1'b0, rb};
      test = 1'b0;
      step();
      chk("rnd_norm", 8'(s), 8'(e));
      test = 1'b1;
      step();
      chk("rnd_test", 8'(s), 8'(e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
